// File: rtl/bsg_chip_pkg.sv
// Shared chip-level types: wormhole header layout macro and mem-link group constants.
`ifndef BSG_CHIP_PKG_SV
`define BSG_CHIP_PKG_SV

// Header layout, LSB first: cord, len, cid, then payload in the remaining bits.
`define BSG_CHIP_DECLARE_WH_HEADER_S(flit_w, cord_w, len_w, cid_w, struct_name) \
    typedef struct packed { \
        logic [(flit_w)-(cid_w)-(len_w)-(cord_w)-1:0] payload; \
        logic [(cid_w)-1:0]                           cid; \
        logic [(len_w)-1:0]                           len; \
        logic [(cord_w)-1:0]                          cord; \
    } struct_name

package bsg_chip_pkg;

    localparam int mem_link_rr_ratio_gp = 2;

    typedef enum logic {
        pkt_idle_e = 1'b0,
        pkt_busy_e = 1'b1
    } pkt_state_e;

endpackage

`endif

// File: rtl/bsg_chip_wh_pkt_len_tracker.sv
// Tracks one wormhole packet's body flits; busy_o is the packet FSM state.
module bsg_chip_wh_pkt_len_tracker
    import bsg_chip_pkg::*;
#(
    parameter int len_width_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   accept_i,
    input  logic                   is_header_i,
    input  logic [len_width_p-1:0] len_i,
    output logic                   busy_o,
    output logic                   last_o
);

    localparam logic [len_width_p-1:0] one_lp = {{(len_width_p-1){1'b0}}, 1'b1};

    pkt_state_e             state_r;
    logic [len_width_p-1:0] rem_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= pkt_idle_e;
            rem_r   <= '0;
        end else if (accept_i) begin
            case (state_r)
                pkt_idle_e: begin
                    if (is_header_i && (len_i != '0)) begin
                        state_r <= pkt_busy_e;
                        rem_r   <= len_i;
                    end
                end
                default: begin
                    // rem_r is never decremented from zero: BUSY always exits at one.
                    rem_r <= rem_r - one_lp;
                    if (rem_r == one_lp) begin
                        state_r <= pkt_idle_e;
                    end
                end
            endcase
        end
    end

    assign busy_o = (state_r == pkt_busy_e);
    assign last_o = (state_r == pkt_idle_e) ? (is_header_i && (len_i == '0))
                                            : (rem_r == one_lp);

endmodule

// File: rtl/bsg_chip_mem_link_wh_packet_rr.sv
// Packet-atomic round-robin between one concentrated wormhole link and a group of mem links.
// Optional macro BSG_CHIP_MEM_LINK_WH_PACKET_RR_PERF_EN enables the packet counters.
module bsg_chip_mem_link_wh_packet_rr
    import bsg_chip_pkg::*;
#(
    parameter int flit_width_p = 32,
    parameter int cord_width_p = 7,
    parameter int len_width_p  = 4,
    parameter int cid_width_p  = 2,
    parameter int num_out_p    = mem_link_rr_ratio_gp,
    localparam int link_sif_width_lp = flit_width_p + 2
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [link_sif_width_lp-1:0]           single_link_i,
    output logic [link_sif_width_lp-1:0]           single_link_o,
    input  logic [num_out_p*link_sif_width_lp-1:0] links_i,
    output logic [num_out_p*link_sif_width_lp-1:0] links_o,
    output logic [31:0]                            egr_pkt_count_o,
    output logic [31:0]                            ing_pkt_count_o
);

    localparam int ptr_width_lp = $clog2(num_out_p);

    `BSG_CHIP_DECLARE_WH_HEADER_S(flit_width_p, cord_width_p, len_width_p, cid_width_p, wh_header_s);

    function automatic logic [len_width_p-1:0] hdr_len(input wh_header_s h);
        return h.len;
    endfunction

    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(num_out_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Link fields: {v, data, ready_and_rev}, v in the MSB.
    logic                    single_v, single_ready;
    logic [flit_width_p-1:0] single_data;
    logic [num_out_p-1:0]    in_v, in_ready;
    logic [flit_width_p-1:0] in_data [num_out_p];
    logic [num_out_p-1:0]    out_v, out_ready;

    assign single_v     = single_link_i[link_sif_width_lp-1];
    assign single_data  = single_link_i[link_sif_width_lp-2:1];
    assign single_ready = single_link_i[0];

    for (genvar i = 0; i < num_out_p; i++) begin : g_link
        assign in_v[i]     = links_i[i*link_sif_width_lp + link_sif_width_lp-1];
        assign in_data[i]  = links_i[i*link_sif_width_lp + 1 +: flit_width_p];
        assign in_ready[i] = links_i[i*link_sif_width_lp];
        assign links_o[i*link_sif_width_lp +: link_sif_width_lp] = {out_v[i], single_data, out_ready[i]};
    end

    logic [ptr_width_lp-1:0] egr_ptr_r, ing_ptr_r, gnt_r;

    // Egress: the concentrated link always faces exactly the pointed-to mem link.
    logic egr_ready, egr_accept, egr_busy, egr_last;

    always_comb begin
        out_v     = '0;
        egr_ready = 1'b0;
        if (!reset_i) begin
            out_v[egr_ptr_r] = single_v;
            egr_ready        = in_ready[egr_ptr_r];
        end
    end

    assign egr_accept = single_v & egr_ready;

    bsg_chip_wh_pkt_len_tracker #(.len_width_p(len_width_p)) egr_tracker (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .accept_i   (egr_accept),
        .is_header_i(!egr_busy),
        .len_i      (hdr_len(single_data)),
        .busy_o     (egr_busy),
        .last_o     (egr_last)
    );

    // Ingress: search from ing_ptr_r while idle, hold the granted link while locked.
    logic                    ing_busy, ing_last, ing_found, ing_v, ing_accept;
    logic [ptr_width_lp-1:0] ing_sel, cand;
    logic [flit_width_p-1:0] ing_data;
    int unsigned             sum;

    always_comb begin
        ing_sel   = ing_ptr_r;
        ing_found = 1'b0;
        cand      = '0;
        sum       = 0;
        if (ing_busy) begin
            ing_sel   = gnt_r;
            ing_found = 1'b1;
        end else begin
            for (int k = 0; k < num_out_p; k++) begin
                sum = int'(ing_ptr_r) + k;
                if (sum >= num_out_p) begin
                    sum = sum - num_out_p;
                end
                cand = ptr_width_lp'(sum);
                if (!ing_found && in_v[cand]) begin
                    ing_sel   = cand;
                    ing_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_ready = '0;
        if (!reset_i && ing_found) begin
            out_ready[ing_sel] = single_ready;
        end
    end

    assign ing_v      = !reset_i && ing_found && in_v[ing_sel];
    assign ing_data   = in_data[ing_sel];
    assign ing_accept = ing_v & single_ready;

    bsg_chip_wh_pkt_len_tracker #(.len_width_p(len_width_p)) ing_tracker (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .accept_i   (ing_accept),
        .is_header_i(!ing_busy),
        .len_i      (hdr_len(ing_data)),
        .busy_o     (ing_busy),
        .last_o     (ing_last)
    );

    assign single_link_o = {ing_v, ing_data, egr_ready};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            egr_ptr_r <= '0;
            ing_ptr_r <= '0;
            gnt_r     <= '0;
        end else begin
            if (egr_accept && egr_last) begin
                egr_ptr_r <= next_ptr(egr_ptr_r);
            end
            if (ing_accept && !ing_busy) begin
                gnt_r <= ing_sel;
            end
            if (ing_accept && ing_last) begin
                ing_ptr_r <= next_ptr(ing_sel);
            end
        end
    end

`ifdef BSG_CHIP_MEM_LINK_WH_PACKET_RR_PERF_EN
    logic [31:0] egr_cnt_r, ing_cnt_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            egr_cnt_r <= '0;
            ing_cnt_r <= '0;
        end else begin
            if (egr_accept && egr_last) begin
                egr_cnt_r <= egr_cnt_r + 32'd1;
            end
            if (ing_accept && ing_last) begin
                ing_cnt_r <= ing_cnt_r + 32'd1;
            end
        end
    end

    assign egr_pkt_count_o = egr_cnt_r;
    assign ing_pkt_count_o = ing_cnt_r;
`else
    assign egr_pkt_count_o = '0;
    assign ing_pkt_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_chip_mem_link_wh_packet_rr.sv
// Scoreboard bench for bsg_chip_mem_link_wh_packet_rr: egress rotation, stall, ingress arbitration, reset.
module tb_bsg_chip_mem_link_wh_packet_rr;

    localparam int fw = 32;
    localparam int n  = 2;
    localparam int w  = fw + 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        s_v, s_rdy;
    logic [31:0] s_data;
    logic        l_v   [n];
    logic        l_rdy [n];
    logic [31:0] l_data[n];

    logic [w-1:0]   single_link_i, single_link_o;
    logic [n*w-1:0] links_i, links_o;
    logic [31:0]    egr_cnt, ing_cnt;

    assign single_link_i = {s_v, s_data, s_rdy};
    for (genvar gi = 0; gi < n; gi++) begin : g_l
        assign links_i[gi*w +: w] = {l_v[gi], l_data[gi], l_rdy[gi]};
    end

    bsg_chip_mem_link_wh_packet_rr #(
        .flit_width_p(32), .cord_width_p(7), .len_width_p(4), .cid_width_p(2), .num_out_p(n)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .single_link_i  (single_link_i),
        .single_link_o  (single_link_o),
        .links_i        (links_i),
        .links_o        (links_o),
        .egr_pkt_count_o(egr_cnt),
        .ing_pkt_count_o(ing_cnt)
    );

    logic [32:0] egr_exp_q[$];
    logic [31:0] ing_exp_q[$];
    int checks = 0;
    int passes = 0;
    int model_ptr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [31:0] mk_hdr(input int tag, input int len);
        return (32'(tag) << 13) | (32'(len) << 7);
    endfunction

    function automatic logic [31:0] mk_body(input int tag, input int k);
        return (32'(tag) << 13) | 32'h1000 | 32'(k);
    endfunction

    // Monitor: every completed transfer on any output pops the matching queue.
    logic [32:0] got, e;
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < n; i++) begin
                if (links_o[i*w + w-1] && l_rdy[i]) begin
                    got = {1'(i), links_o[i*w + 1 +: 32]};
                    if (egr_exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL egr_unexpected actual=%0h required=none", got);
                    end else begin
                        e = egr_exp_q.pop_front();
                        check("egr_flit", 64'(got), 64'(e));
                    end
                end
            end
            if (single_link_o[w-1] && s_rdy) begin
                if (ing_exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL ing_unexpected actual=%0h required=none", single_link_o[w-2:1]);
                end else begin
                    check("ing_flit", 64'(single_link_o[w-2:1]), 64'(ing_exp_q.pop_front()));
                end
            end
        end
    end

    task automatic egr_flit(input logic [31:0] d, input int link);
        int cyc;
        logic acc;
        egr_exp_q.push_back({link[0], d});
        s_v = 1'b1;
        s_data = d;
        cyc = 0;
        acc = 1'b0;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = single_link_o[0];
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!acc) begin
            checks++;
            $display("FAIL egr_timeout actual=stalled required=accepted data=%0h", d);
        end
    endtask

    task automatic egr_pkt(input int len, input int tag);
        egr_flit(mk_hdr(tag, len), model_ptr);
        for (int k = 1; k <= len; k++) egr_flit(mk_body(tag, k), model_ptr);
        s_v = 1'b0;
        model_ptr = (model_ptr + 1) % n;
    endtask

    task automatic ing_push(input int len, input int tag);
        ing_exp_q.push_back(mk_hdr(tag, len));
        for (int k = 1; k <= len; k++) ing_exp_q.push_back(mk_body(tag, k));
    endtask

    task automatic ing_pkt(input int idx, input int len, input int tag);
        int cyc;
        logic acc;
        for (int f = 0; f <= len; f++) begin
            l_v[idx] = 1'b1;
            l_data[idx] = (f == 0) ? mk_hdr(tag, len) : mk_body(tag, f);
            cyc = 0;
            acc = 1'b0;
            while (!acc && cyc < 60) begin
                @(negedge clk);
                acc = links_o[idx*w];
                @(posedge clk);
                #1;
                cyc++;
            end
            if (!acc) begin
                checks++;
                $display("FAIL ing_timeout link=%0d actual=stalled required=accepted", idx);
            end
        end
        l_v[idx] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Drive everything active during reset so the gating is observable.
        reset = 1'b1;
        s_v = 1'b1; s_data = 32'hdead_beef; s_rdy = 1'b1;
        for (int i = 0; i < n; i++) begin
            l_v[i] = 1'b1; l_rdy[i] = 1'b1; l_data[i] = 32'h1234_0000 + 32'(i);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_single_v", 64'(single_link_o[w-1]), 0);
        check("rst_single_rdy", 64'(single_link_o[0]), 0);
        check("rst_link0_v", 64'(links_o[w-1]), 0);
        check("rst_link1_v", 64'(links_o[2*w-1]), 0);
        check("rst_link0_rdy", 64'(links_o[0]), 0);
        check("rst_link1_rdy", 64'(links_o[w]), 0);
        check("rst_egr_cnt", 64'(egr_cnt), 0);
        check("rst_ing_cnt", 64'(ing_cnt), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        s_v = 1'b0;
        for (int i = 0; i < n; i++) l_v[i] = 1'b0;

        // Egress back-to-back: links 0, 1, 0.
        egr_pkt(2, 1);
        egr_pkt(0, 2);
        egr_pkt(3, 3);

        // Egress stall on link 1 for five cycles.
        l_rdy[1] = 1'b0;
        s_v = 1'b1;
        s_data = mk_hdr(4, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_ready", 64'(single_link_o[0]), 0);
            check("stall_no_link0", 64'(links_o[w-1]), 0);
            check("stall_link1_v", 64'(links_o[2*w-1]), 1);
            @(posedge clk);
            #1;
        end
        l_rdy[1] = 1'b1;
        egr_pkt(1, 4);

        // Ingress: both links present len 1 headers in the same cycle.
        ing_push(1, 10);
        ing_push(1, 11);
        fork
            ing_pkt(0, 1, 10);
            ing_pkt(1, 1, 11);
            begin
                @(negedge clk);
                check("arb_link1_held", 64'(links_o[w]), 0);
                check("arb_link0_ready", 64'(links_o[0]), 1);
            end
        join

        // Ingress: max-length packet on link 1 locks out link 0.
        ing_push(15, 20);
        ing_push(0, 21);
        fork
            ing_pkt(1, 15, 20);
            begin
                @(posedge clk);
                #1;
                ing_pkt(0, 0, 21);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                check("lock_link0_held", 64'(links_o[0]), 0);
                check("lock_link1_ready", 64'(links_o[w]), 1);
            end
        join

        // Reset on the second body flit of a len 3 packet to link 1.
        egr_pkt(0, 30);
        egr_flit(mk_hdr(31, 3), 1);
        egr_flit(mk_body(31, 1), 1);
        s_data = mk_body(31, 2);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_link0_v", 64'(links_o[w-1]), 0);
        check("midrst_link1_v", 64'(links_o[2*w-1]), 0);
        check("midrst_single_rdy", 64'(single_link_o[0]), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        s_v = 1'b0;
        model_ptr = 0;
        @(negedge clk);
        check("postrst_link1_v", 64'(links_o[2*w-1]), 0);
        check("postrst_egr_cnt", 64'(egr_cnt), 0);
        check("postrst_ing_cnt", 64'(ing_cnt), 0);
        @(posedge clk);
        #1;
        egr_pkt(0, 32);

        // Concurrent traffic: 9 more egress packets, 7 ingress packets.
        fork
            for (int j = 0; j < 9; j++) egr_pkt(j % 3, 50 + j);
            for (int j = 0; j < 7; j++) begin
                ing_push(j % 3, 70 + j);
                ing_pkt(j % 2, j % 3, 70 + j);
            end
        join
        repeat (2) @(posedge clk);
        @(negedge clk);
`ifdef BSG_CHIP_MEM_LINK_WH_PACKET_RR_PERF_EN
        check("egr_pkt_count", 64'(egr_cnt), 10);
        check("ing_pkt_count", 64'(ing_cnt), 7);
`else
        check("egr_pkt_count", 64'(egr_cnt), 0);
        check("ing_pkt_count", 64'(ing_cnt), 0);
`endif
        check("egr_q_drained", 64'(egr_exp_q.size()), 0);
        check("ing_q_drained", 64'(ing_exp_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
